// File: rtl/mci_cif_seq_initiator_pkg.sv
// Shared types and constants for the MCI cif_if sequencing initiator.
//   - bus widths of the cif_if request payload
//   - maximum command length and the width of a dword count
//   - FSM state encoding, request payload struct, latched command struct
package mci_cif_seq_initiator_pkg;

    localparam int MCI_CIF_ADDR_WIDTH     = 32;
    localparam int MCI_CIF_DATA_WIDTH     = 32;
    localparam int MCI_CIF_USER_WIDTH     = 32;
    localparam int MCI_CIF_ID_WIDTH       = 8;
    localparam int MCI_CIF_SEQ_MAX_LEN_DW = 256;
    localparam int MCI_CIF_SEQ_LEN_W      = $clog2(MCI_CIF_SEQ_MAX_LEN_DW + 1);

    typedef enum logic [2:0] {
        MCI_CIF_SEQ_IDLE = 3'd0,
        MCI_CIF_SEQ_LOAD = 3'd1,
        MCI_CIF_SEQ_REQ  = 3'd2,
        MCI_CIF_SEQ_RSP  = 3'd3,
        MCI_CIF_SEQ_DONE = 3'd4
    } mci_cif_seq_state_e;

    // One single-dword cif_if transaction request.
    typedef struct packed {
        logic [MCI_CIF_ADDR_WIDTH-1:0]   addr;
        logic [MCI_CIF_DATA_WIDTH-1:0]   wdata;
        logic [MCI_CIF_DATA_WIDTH/8-1:0] wstrb;
        logic                            write;
        logic [MCI_CIF_USER_WIDTH-1:0]   user;
        logic [MCI_CIF_ID_WIDTH-1:0]     id;
    } mci_cif_req_t;

    // Command being executed: addr is the current dword address and
    // len_dw the number of dwords still to move.
    typedef struct packed {
        logic [MCI_CIF_ADDR_WIDTH-1:0] addr;
        logic [MCI_CIF_SEQ_LEN_W-1:0]  len_dw;
        logic                          write;
        logic [MCI_CIF_USER_WIDTH-1:0] user;
    } mci_cif_seq_cmd_t;

endpackage

// File: rtl/mci_cif_seq_initiator_if.sv
// cif_if request-side bundle between an initiator and an MCI sub target.
//   dv       initiator -> target  transaction valid; never drops while hold = 1
//   req_data initiator -> target  addr/wdata/wstrb/write/user/id, stable while dv = 1
//   hold     target -> initiator  stall; the transaction completes on dv & ~hold
//   error    target -> initiator  sampled only in the completion cycle
//   rdata    target -> initiator  sampled only in the completion cycle
// Handshake: a transaction is issued when dv rises and completes on the first
// cycle with dv & ~hold; req_data is held constant from dv rising to completion.
interface mci_cif_seq_initiator_if;
    import mci_cif_seq_initiator_pkg::*;

    logic                          dv;
    mci_cif_req_t                  req_data;
    logic                          hold;
    logic                          error;
    logic [MCI_CIF_DATA_WIDTH-1:0] rdata;

    modport master (
        output dv,
        output req_data,
        input  hold,
        input  error,
        input  rdata
    );

    modport slave (
        input  dv,
        input  req_data,
        output hold,
        output error,
        output rdata
    );

endinterface

// File: rtl/mci_cif_seq_initiator.sv
// Sequencing initiator: runs one multi-dword read or write command as a chain
// of single-dword cif_if transactions, streaming write data in and read data out.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_if (master)       cif_if request side
//   cmd_valid/cmd_ready   command handshake; cmd_addr, cmd_len_dw, cmd_write, cmd_user
//   wr_valid/wr_ready     write dword stream in (wr_data)
//   rd_valid/rd_ready     read dword stream out (rd_data)
//   done, done_err        one-cycle end-of-command pulse and its failure flag
//   err_addr              address of the failing transaction, held until the next accept
//   state_dbg             current FSM state
// All valid/ready ports transfer on a cycle with valid & ready both high; a
// producer keeps valid and its data stable until that cycle.
module mci_cif_seq_initiator
    import mci_cif_seq_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = MCI_CIF_ADDR_WIDTH,
    parameter int DATA_WIDTH = MCI_CIF_DATA_WIDTH,
    parameter int USER_WIDTH = MCI_CIF_USER_WIDTH,
    parameter int MAX_LEN_DW = MCI_CIF_SEQ_MAX_LEN_DW,
    localparam int LEN_W     = $clog2(MAX_LEN_DW + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    mci_cif_seq_initiator_if.master   req_if,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [LEN_W-1:0]          cmd_len_dw,
    input  logic                      cmd_write,
    input  logic [USER_WIDTH-1:0]     cmd_user,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      done,
    output logic                      done_err,
    output logic [ADDR_WIDTH-1:0]     err_addr,
    output logic [2:0]                state_dbg
);

    localparam logic [2:0] ST_IDLE = MCI_CIF_SEQ_IDLE;
    localparam logic [2:0] ST_LOAD = MCI_CIF_SEQ_LOAD;
    localparam logic [2:0] ST_REQ  = MCI_CIF_SEQ_REQ;
    localparam logic [2:0] ST_RSP  = MCI_CIF_SEQ_RSP;
    localparam logic [2:0] ST_DONE = MCI_CIF_SEQ_DONE;

    localparam int EW = ADDR_WIDTH + 1;

    logic [2:0]            state;
    mci_cif_seq_cmd_t      cmd_q;
    logic                  dv_q;
    mci_cif_req_t          req_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;
    logic                  err_q;

    // Command pre-check. The end address is computed one bit wider so that a
    // command ending exactly at the top of the address space is still legal.
    logic [EW-1:0] end_addr;
    logic          cmd_bad;
    logic          last_dw;
    logic          completion;

    always_comb begin
        end_addr = {1'b0, cmd_addr} + EW'({cmd_len_dw, 2'b00});
        cmd_bad  = (|cmd_addr[1:0])
                 || (cmd_len_dw > LEN_W'(MAX_LEN_DW))
                 || (end_addr[ADDR_WIDTH] && (|end_addr[ADDR_WIDTH-1:0]));
    end

    assign last_dw    = (cmd_q.len_dw == LEN_W'(1));
    assign completion = dv_q && !req_if.hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cmd_q      <= '0;
            dv_q       <= 1'b0;
            req_q      <= '0;
            rd_data_q  <= '0;
            err_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q.addr   <= cmd_addr;
                        cmd_q.len_dw <= cmd_len_dw;
                        cmd_q.write  <= cmd_write;
                        cmd_q.user   <= cmd_user;
                        req_q.addr   <= cmd_addr;
                        req_q.wdata  <= '0;
                        req_q.wstrb  <= '1;
                        req_q.write  <= cmd_write;
                        req_q.user   <= cmd_user;
                        req_q.id     <= '0;
                        err_addr_q   <= '0;
                        err_q        <= 1'b0;
                        if (cmd_bad) begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end else if (cmd_len_dw == '0) begin
                            state <= ST_DONE;
                        end else if (cmd_write) begin
                            state <= ST_LOAD;
                        end else begin
                            dv_q  <= 1'b1;
                            state <= ST_REQ;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_valid) begin
                        req_q.wdata <= wr_data;
                        dv_q        <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (completion) begin
                        dv_q <= 1'b0;
                        if (req_if.error) begin
                            err_addr_q <= cmd_q.addr;
                            err_q      <= 1'b1;
                            state      <= ST_DONE;
                        end else if (cmd_q.write) begin
                            cmd_q.addr   <= cmd_q.addr + ADDR_WIDTH'(4);
                            req_q.addr   <= cmd_q.addr + ADDR_WIDTH'(4);
                            cmd_q.len_dw <= last_dw ? '0 : cmd_q.len_dw - LEN_W'(1);
                            state        <= last_dw ? ST_DONE : ST_LOAD;
                        end else begin
                            rd_data_q <= req_if.rdata;
                            state     <= ST_RSP;
                        end
                    end
                end
                ST_RSP: begin
                    if (rd_ready) begin
                        cmd_q.addr   <= cmd_q.addr + ADDR_WIDTH'(4);
                        req_q.addr   <= cmd_q.addr + ADDR_WIDTH'(4);
                        cmd_q.len_dw <= last_dw ? '0 : cmd_q.len_dw - LEN_W'(1);
                        if (last_dw) begin
                            state <= ST_DONE;
                        end else begin
                            dv_q  <= 1'b1;
                            state <= ST_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    dv_q  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_if.dv       = dv_q;
    assign req_if.req_data = req_q;

    assign cmd_ready = (state == ST_IDLE);
    assign wr_ready  = (state == ST_LOAD);
    assign rd_valid  = (state == ST_RSP);
    assign rd_data   = rd_data_q;
    assign done      = (state == ST_DONE);
    assign done_err  = done && err_q;
    assign err_addr  = err_addr_q;
    assign state_dbg = state;

endmodule
